// File: rtl/dlfloat_mac_collector.sv
// Collects DLfloat16 MAC results per vector into a result FIFO; output visible 1+MAC_LAT cycles after the last term; valid/ready, a push into a full FIFO drops and sets sticky overflow.
// Optional per-entry NaN/Inf flag output (out_nan) enabled by defining DLF_COLLECT_NAN_FLAG_EN.
module dlfloat_mac_collector #(
  parameter int MAC_LAT = 3,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [15:0]      mac_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_cnt,
`ifdef DLF_COLLECT_NAN_FLAG_EN
  output logic             out_nan,
`endif
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
`ifdef DLF_COLLECT_NAN_FLAG_EN
    logic             nan;
`endif
    logic [CNT_W-1:0] cnt;
    logic [15:0]      data;
  } entry_t;

  // Delay line tracking term qualifiers alongside the MAC pipeline
  logic [MAC_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [MAC_LAT-1:0] lst_sr_q, lst_sr_d;
  logic               d_vld, d_lst;

  always_comb begin
    vld_sr_d    = vld_sr_q;
    lst_sr_d    = lst_sr_q;
    vld_sr_d[0] = in_valid;
    lst_sr_d[0] = in_valid & in_last;
    for (int i = 1; i < MAC_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      lst_sr_d[i] = lst_sr_q[i-1];
    end
  end

  assign d_vld = vld_sr_q[MAC_LAT-1];
  assign d_lst = lst_sr_q[MAC_LAT-1];

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (d_vld) begin
      cnt_d = d_lst ? '0 : cnt_inc;
    end
  end

  // Result FIFO: extra pointer MSB distinguishes full from empty
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      mem_q [DEPTH];
  entry_t      wr_entry;
  entry_t      head;
  logic        full, empty, push, pop, wr_en;
  logic        ovf_q, ovf_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = d_vld & d_lst;
  assign pop   = ~empty & out_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = mac_out;
    wr_entry.cnt  = cnt_inc;
`ifdef DLF_COLLECT_NAN_FLAG_EN
    wr_entry.nan  = (mac_out == 16'hFFFF);
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr_q <= '0;
      lst_sr_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_sr_q <= vld_sr_d;
      lst_sr_q <= lst_sr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  // Storage is not reset, so outputs are gated by occupancy
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = ~empty;
  assign out_data  = out_valid ? head.data : '0;
  assign out_cnt   = out_valid ? head.cnt  : '0;
  assign overflow  = ovf_q;
`ifdef DLF_COLLECT_NAN_FLAG_EN
  assign out_nan   = out_valid & head.nan;
`endif

endmodule

// File: tb/tb_dlfloat_mac_collector.sv
// Bench for dlfloat_mac_collector: queue-based reference model checked every cycle, plus directed literal checks.
module tb_dlfloat_mac_collector;
  localparam int MAC_LAT = 3;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [15:0]      mac_out = 16'h0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             overflow;
`ifdef DLF_COLLECT_NAN_FLAG_EN
  logic             out_nan;
`endif

  always #5 clk = ~clk;

  dlfloat_mac_collector #(.MAC_LAT(MAC_LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .mac_out  (mac_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt),
`ifdef DLF_COLLECT_NAN_FLAG_EN
    .out_nan  (out_nan),
`endif
    .overflow (overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle history of term qualifiers, a result queue, a counter
  typedef struct {
    logic [15:0] data;
    int          cnt;
    bit          nan;
  } res_t;

  res_t m_q[$];
  res_t m_r;
  bit   hv[MAC_LAT];
  bit   hl[MAC_LAT];
  bit   m_dv, m_dl;
  int   m_cnt = 0;
  int   m_next;
  bit   m_ovf = 1'b0;
  bit   model_init = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        hv[i] = 1'b0;
        hl[i] = 1'b0;
      end
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      model_init = 1'b1;
    end else begin
      m_dv = hv[MAC_LAT-1];
      m_dl = hl[MAC_LAT-1];
      for (int i = MAC_LAT-1; i > 0; i--) begin
        hv[i] = hv[i-1];
        hl[i] = hl[i-1];
      end
      hv[0] = in_valid;
      hl[0] = in_valid & in_last;
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (m_dv) begin
        m_next = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (m_dl) begin
          if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1;
          end else begin
            m_r.data = mac_out;
            m_r.cnt  = m_next;
            m_r.nan  = (mac_out == 16'hFFFF);
            m_q.push_back(m_r);
          end
          m_cnt = 0;
        end else begin
          m_cnt = m_next;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_init) begin
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() != 0 && out_valid) begin
        check("out_data", 32'(out_data), 32'(m_q[0].data));
        check("out_cnt", 32'(out_cnt), 32'(m_q[0].cnt));
`ifdef DLF_COLLECT_NAN_FLAG_EN
        check("out_nan", 32'(out_nan), 32'(m_q[0].nan));
`endif
      end
    end
  end

  task automatic drive(input bit v, input bit l);
    in_valid = v;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain4(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
    @(negedge clk);
    check({nm, "_head0"}, 32'(out_data), 32'(e0));
    out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_head1"}, 32'(out_data), 32'(e1));
    @(negedge clk);
    check({nm, "_head2"}, 32'(out_data), 32'(e2));
    @(negedge clk);
    check({nm, "_head3"}, 32'(out_data), 32'(e3));
    @(negedge clk);
    check({nm, "_empty"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);

    // Four terms, last on the fourth
    out_ready = 1'b1;
    mac_out   = 16'h3E00;
    drive(1, 0); drive(1, 0); drive(1, 0); drive(1, 1);
    wait_valid("t1", n);
    check("t1_latency", 32'(n), 32'(1 + MAC_LAT));
    check("t1_data", 32'(out_data), 32'h3E00);
    check("t1_cnt", 32'(out_cnt), 32'd4);
    repeat (MAC_LAT + 2) @(posedge clk);
    #1;

    // Gaps are not counted
    mac_out = 16'h4000;
    drive(1, 0); drive(0, 0); drive(1, 0); drive(1, 0); drive(0, 0); drive(1, 1);
    wait_valid("t2", n);
    check("t2_cnt", 32'(out_cnt), 32'd4);
    check("t2_data", 32'(out_data), 32'h4000);

    // DEPTH+1 single-term vectors with the consumer stalled
    do_reset();
    for (int j = 0; j < 5 + MAC_LAT; j++) begin
      in_valid = (j < 5);
      in_last  = (j < 5);
      mac_out  = (j >= MAC_LAT) ? 16'(16'h100 + j - MAC_LAT) : 16'h0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_cnt", 32'(out_cnt), 32'd1);
    drain4("t3", 16'h100, 16'h101, 16'h102, 16'h103);

    // Push and pop on the same edge while full
    do_reset();
    for (int j = 0; j < 6 + MAC_LAT; j++) begin
      in_valid  = (j < 4) || (j == 5);
      in_last   = (j < 4) || (j == 5);
      mac_out   = (j >= MAC_LAT) ? 16'(16'h200 + j - MAC_LAT) : 16'h0;
      out_ready = (j == 5 + MAC_LAT);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    drain4("t4", 16'h201, 16'h202, 16'h203, 16'h205);
    check("t4_overflow", 32'(overflow), 32'd0);

    // Reset with terms in flight
    do_reset();
    out_ready = 1'b1;
    mac_out   = 16'h1234;
    drive(1, 0); drive(1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 1);
    wait_valid("t5", n);
    check("t5_cnt", 32'(out_cnt), 32'd1);
    check("t5_data", 32'(out_data), 32'h1234);
    repeat (MAC_LAT + 4) @(negedge clk);
    check("t5_no_extra", 32'(out_valid), 32'd0);

    // NaN/Inf pass-through
    do_reset();
    out_ready = 1'b1;
    mac_out   = 16'hFFFF;
    drive(1, 1);
    wait_valid("t6a", n);
    check("t6_nan_data", 32'(out_data), 32'hFFFF);
`ifdef DLF_COLLECT_NAN_FLAG_EN
    check("t6_nan_flag", 32'(out_nan), 32'd1);
`endif
    mac_out = 16'h3C00;
    drive(1, 1);
    wait_valid("t6b", n);
    check("t6_num_data", 32'(out_data), 32'h3C00);
`ifdef DLF_COLLECT_NAN_FLAG_EN
    check("t6_num_flag", 32'(out_nan), 32'd0);
`endif

    // Counter saturation
    do_reset();
    out_ready = 1'b1;
    mac_out   = 16'h5555;
    for (int i = 0; i < 299; i++) drive(1, 0);
    drive(1, 1);
    wait_valid("t7", n);
    check("t7_cnt_sat", 32'(out_cnt), 32'd255);

    // Randomized traffic with varying consumer rate and occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 4) == 0);
      mac_out   = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      case ((i / 500) % 3)
        0:       out_ready = ($urandom_range(0, 9) < 8);
        1:       out_ready = ($urandom_range(0, 9) < 3);
        default: out_ready = ($urandom_range(0, 9) < 5);
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      #1;
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (MAC_LAT + DEPTH + 4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
